acltxbuf_ctrl: RTL and testbench
================================

# acltxbuf_ctrl

ACL transmit ping-pong payload buffer controller. It sits directly downstream of the ARQ/flow-control stage and consumes its per-packet retransmission decision (`sendnewpy` / `sendoldpy` / `send0py`). It selects which of two MCU-filled payload buffers the packet encoder transmits, and frees a buffer once its payload is acknowledged. It tracks a single active ACL link.

## Interface
- No parameters.
- `clk_6M`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `connsnew_p`  in  1  new connection; synchronous clear of all buffer state.
- `mcu_load_p`  in  1  MCU has finished writing buffer `wrbuf_sel`.
- `mcu_load_len`  in  10  payload length in bytes for that load.
- `mcu_flush_p`  in  1  discard all queued and in-flight payloads.
- `pk_encode`  in  1  current slot is a TX slot.
- `header_st_p`  in  1  header start strobe; this is the decision point.
- `sendnewpy`, `sendoldpy`, `send0py`  in  1 each  ARQ decision, stable while `header_st_p` is high.
- `wrbuf_sel`  out  1  buffer the MCU writes next.
- `wrbuf_avail`  out  1  `wrbuf_sel` is EMPTY.
- `txbuf_sel`  out  1  buffer the encoder reads.
- `tx_pylen`  out  10  payload length for the encoder.
- `tx_nullpkt`  out  1  no payload is available; the encoder substitutes a NULL packet.
- `tx_decision_p`  out  1  one-cycle pulse: the `tx_*` outputs were updated.
- `txbuf_released_p`  out  1  an acknowledged buffer was freed.
- `flush_done_p`  out  1  flush completed.
- `load_overrun`  out  1  sticky flag: a load arrived with no free buffer.

## Operation
- Each buffer has a 2-bit state: EMPTY=0, LOADED=1, INFLIGHT=2.
  - At most one buffer is INFLIGHT.
  - Each buffer has a 10-bit length register.
  - An `older` bit marks the first-loaded buffer when both are LOADED.
- **Write-buffer selection:** `wrbuf_sel` is the lowest-index EMPTY buffer, or 0 when neither is EMPTY. `wrbuf_avail` = 1 when any buffer is EMPTY.
- **Load:** on `mcu_load_p` with `wrbuf_avail`, buffer `wrbuf_sel` becomes LOADED and latches `mcu_load_len`. If the other buffer is already LOADED, `older` points to the other buffer. A load with `wrbuf_avail`=0 is dropped and sets `load_overrun`.
- **Decision:** evaluated when `pk_encode & header_st_p` is high.
  - `sendnewpy`:
    - The INFLIGHT buffer, if any, goes to EMPTY and `txbuf_released_p` pulses.
    - The oldest LOADED buffer then goes to INFLIGHT, with `txbuf_sel` = that buffer, `tx_pylen` = its length, `tx_nullpkt` = 0.
    - If no buffer is LOADED: `tx_nullpkt` = 1 and `tx_pylen` = 0.
  - `sendoldpy`:
    - If a buffer is INFLIGHT: `txbuf_sel` = the INFLIGHT buffer, `tx_pylen` = its length, `tx_nullpkt` = 0, and no state changes.
    - If no buffer is INFLIGHT (first packet): same as `sendnewpy` without a release.
  - `send0py`: `tx_pylen` = 0, `tx_nullpkt` = 0, and the INFLIGHT buffer is kept.
  - None of the three asserted (non-ACL packet type): no state change, `tx_*` outputs hold, and no `tx_decision_p`.
  - More than one asserted: priority is `send0py` > `sendoldpy` > `sendnewpy`.
- **Flush:** every buffer goes to EMPTY, `older` is cleared, and `flush_done_p` pulses. No release pulse is generated.
- **Priority:** `rst` > `connsnew_p` > flush > decision.
  - A decision coinciding with a flush sees all buffers EMPTY: it produces `tx_nullpkt` = 1 and pulses `tx_decision_p`.
  - A load coinciding with a flush or with `connsnew_p` is dropped and does not set `load_overrun`.
- **Load with decision in the same cycle:**
  - The decision uses the pre-cycle state, so the newly loaded buffer is not eligible for this decision.
  - The load always targets a buffer that was EMPTY before the cycle, so the two updates never collide.
- `connsnew_p` has the same effect as reset on all state and outputs, including `load_overrun`.

## Timing
- Reset values:
  - All buffers EMPTY, `older` = 0.
  - `wrbuf_sel` = 0, `wrbuf_avail` = 1.
  - `txbuf_sel` = 0, `tx_pylen` = 0, `tx_nullpkt` = 1.
  - All pulses = 0, `load_overrun` = 0.
- All outputs are registered. The `tx_*` outputs, `tx_decision_p` and `txbuf_released_p` appear on the cycle after `header_st_p`.
- A load is visible in `wrbuf_sel` / `wrbuf_avail` one cycle after `mcu_load_p`.
- A flush takes effect one cycle after `mcu_flush_p`; `flush_done_p` pulses on that same cycle.
- Pulse outputs are high for exactly one cycle.
- `tx_*` outputs hold their values until the next decision.
- `rst` asserted mid-operation clears immediately; no pending pulse survives.

## Test plan
- **Single payload cycle:** reset; load len=27 into buffer 0; decision with `sendoldpy` → `txbuf_sel`=0, `tx_pylen`=27, `tx_nullpkt`=0. Next decision with `sendnewpy` and nothing loaded → `txbuf_released_p`, `tx_nullpkt`=1, `wrbuf_avail`=1, `wrbuf_sel`=0.
- **Queue ordering:** load len=10 into buffer 0, then len=20 into buffer 1 → `wrbuf_avail`=0. `sendnewpy` → `txbuf_sel`=0, `tx_pylen`=10. Next `sendnewpy` → buffer 0 freed, `txbuf_sel`=1, `tx_pylen`=20, `wrbuf_sel`=0.
- **Retransmit and zero-length:** with buffer 1 INFLIGHT (len=183), `sendoldpy` ×3 → `tx_pylen`=183 each time with no release pulse. `send0py` → `tx_pylen`=0, `tx_nullpkt`=0, buffer 1 still INFLIGHT.
- **Overrun:** both buffers occupied; `mcu_load_p` → `load_overrun`=1, state unchanged. `connsnew_p` → `load_overrun`=0 and all buffers EMPTY.
- **Flush versus decision:** `mcu_flush_p` and `sendnewpy` decision in the same cycle with buffer 0 LOADED → `tx_nullpkt`=1, `flush_done_p`, no release pulse, both buffers EMPTY.
- **Load in the decision cycle:** buffer 1 INFLIGHT, buffer 0 EMPTY; `mcu_load_p` (len=5) together with a `sendnewpy` decision → `tx_nullpkt`=1 and buffer 1 released. On the next cycle buffer 0 is LOADED with len=5.

Source files
------------

// File: rtl/acltxbuf_ctrl.sv
// ACL transmit ping-pong payload buffer controller.
// Tracks two MCU-filled payload buffers and serves them to the packet encoder based on the ARQ decision.
module acltxbuf_ctrl (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       connsnew_p,
  input  logic       mcu_load_p,
  input  logic [9:0] mcu_load_len,
  input  logic       mcu_flush_p,
  input  logic       pk_encode,
  input  logic       header_st_p,
  input  logic       sendnewpy,
  input  logic       sendoldpy,
  input  logic       send0py,
  output logic       wrbuf_sel,
  output logic       wrbuf_avail,
  output logic       txbuf_sel,
  output logic [9:0] tx_pylen,
  output logic       tx_nullpkt,
  output logic       tx_decision_p,
  output logic       txbuf_released_p,
  output logic       flush_done_p,
  output logic       load_overrun
);

  typedef enum logic [1:0] {EMPTY = 2'd0, LOADED = 2'd1, INFLIGHT = 2'd2} bst_e;

  bst_e       st   [2];
  bst_e       st_n [2];
  bst_e       vst  [2];
  logic [9:0] len   [2];
  logic [9:0] len_n [2];
  logic       older, older_n;

  logic       wsel_n, wavail_n, sel_n, null_n, dec_n, rel_n, fd_n, ovr_n;
  logic [9:0] pylen_n;
  logic       decide, inf_any, inf_idx, ld_any, oldest;

  assign decide = pk_encode & header_st_p & (sendnewpy | sendoldpy | send0py);

  always_comb begin
    st_n    = st;
    len_n   = len;
    older_n = older;
    sel_n   = txbuf_sel;
    pylen_n = tx_pylen;
    null_n  = tx_nullpkt;
    dec_n   = 1'b0;
    rel_n   = 1'b0;
    fd_n    = 1'b0;
    ovr_n   = load_overrun;

    // A decision coinciding with a flush evaluates against an all-empty view.
    for (int i = 0; i < 2; i++) vst[i] = mcu_flush_p ? EMPTY : st[i];
    inf_any = (vst[0] == INFLIGHT) | (vst[1] == INFLIGHT);
    inf_idx = (vst[1] == INFLIGHT);
    ld_any  = (vst[0] == LOADED) | (vst[1] == LOADED);
    oldest  = ((vst[0] == LOADED) && (vst[1] == LOADED)) ? older : (vst[1] == LOADED);

    if (decide) begin
      dec_n = 1'b1;
      if (send0py) begin
        pylen_n = 10'd0;
        null_n  = 1'b0;
      end else if (sendoldpy && inf_any) begin
        sel_n   = inf_idx;
        pylen_n = len[inf_idx];
        null_n  = 1'b0;
      end else begin
        if (sendnewpy && inf_any) begin
          st_n[inf_idx] = EMPTY;
          rel_n         = 1'b1;
        end
        if (ld_any) begin
          st_n[oldest] = INFLIGHT;
          sel_n        = oldest;
          pylen_n      = len[oldest];
          null_n       = 1'b0;
        end else begin
          pylen_n = 10'd0;
          null_n  = 1'b1;
        end
      end
    end

    // Load target was EMPTY before this cycle, so it never collides with the decision update.
    if (mcu_load_p && !mcu_flush_p) begin
      if (wrbuf_avail) begin
        st_n[wrbuf_sel]  = LOADED;
        len_n[wrbuf_sel] = mcu_load_len;
        if (st[~wrbuf_sel] == LOADED) older_n = ~wrbuf_sel;
      end else begin
        ovr_n = 1'b1;
      end
    end

    if (mcu_flush_p) begin
      st_n[0] = EMPTY;
      st_n[1] = EMPTY;
      older_n = 1'b0;
      fd_n    = 1'b1;
    end

    if (connsnew_p) begin
      st_n[0]  = EMPTY;
      st_n[1]  = EMPTY;
      len_n[0] = 10'd0;
      len_n[1] = 10'd0;
      older_n  = 1'b0;
      sel_n    = 1'b0;
      pylen_n  = 10'd0;
      null_n   = 1'b1;
      dec_n    = 1'b0;
      rel_n    = 1'b0;
      fd_n     = 1'b0;
      ovr_n    = 1'b0;
    end

    wavail_n = (st_n[0] == EMPTY) | (st_n[1] == EMPTY);
    wsel_n   = (st_n[0] != EMPTY) & (st_n[1] == EMPTY);
  end

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      st[0]            <= EMPTY;
      st[1]            <= EMPTY;
      len[0]           <= 10'd0;
      len[1]           <= 10'd0;
      older            <= 1'b0;
      wrbuf_sel        <= 1'b0;
      wrbuf_avail      <= 1'b1;
      txbuf_sel        <= 1'b0;
      tx_pylen         <= 10'd0;
      tx_nullpkt       <= 1'b1;
      tx_decision_p    <= 1'b0;
      txbuf_released_p <= 1'b0;
      flush_done_p     <= 1'b0;
      load_overrun     <= 1'b0;
    end else begin
      st               <= st_n;
      len              <= len_n;
      older            <= older_n;
      wrbuf_sel        <= wsel_n;
      wrbuf_avail      <= wavail_n;
      txbuf_sel        <= sel_n;
      tx_pylen         <= pylen_n;
      tx_nullpkt       <= null_n;
      tx_decision_p    <= dec_n;
      txbuf_released_p <= rel_n;
      flush_done_p     <= fd_n;
      load_overrun     <= ovr_n;
    end
  end

endmodule

// File: tb/tb_acltxbuf_ctrl.sv
// Directed bench for acltxbuf_ctrl; expected decisions are queued and compared on tx_decision_p.
module tb_acltxbuf_ctrl;

  logic       clk_6M = 1'b0;
  logic       rst, connsnew_p, mcu_load_p, mcu_flush_p, pk_encode, header_st_p;
  logic       sendnewpy, sendoldpy, send0py;
  logic [9:0] mcu_load_len;
  logic       wrbuf_sel, wrbuf_avail, txbuf_sel, tx_nullpkt, tx_decision_p;
  logic       txbuf_released_p, flush_done_p, load_overrun;
  logic [9:0] tx_pylen;

  typedef struct {
    logic       sel;
    logic [9:0] len;
    logic       nul;
    logic       rel;
  } exp_t;

  exp_t exp_q[$];
  int   nerr = 0;
  int   nchk = 0;

  acltxbuf_ctrl dut (
    .clk_6M(clk_6M), .rst(rst), .connsnew_p(connsnew_p), .mcu_load_p(mcu_load_p),
    .mcu_load_len(mcu_load_len), .mcu_flush_p(mcu_flush_p), .pk_encode(pk_encode),
    .header_st_p(header_st_p), .sendnewpy(sendnewpy), .sendoldpy(sendoldpy), .send0py(send0py),
    .wrbuf_sel(wrbuf_sel), .wrbuf_avail(wrbuf_avail), .txbuf_sel(txbuf_sel), .tx_pylen(tx_pylen),
    .tx_nullpkt(tx_nullpkt), .tx_decision_p(tx_decision_p), .txbuf_released_p(txbuf_released_p),
    .flush_done_p(flush_done_p), .load_overrun(load_overrun)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every decision pulse consumes one queued expectation.
  always @(negedge clk_6M) begin
    if (tx_decision_p) begin
      if (exp_q.size() == 0) chk("unexpected_decision", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("txbuf_sel", {31'd0, txbuf_sel}, {31'd0, e.sel});
        chk("tx_pylen", {22'd0, tx_pylen}, {22'd0, e.len});
        chk("tx_nullpkt", {31'd0, tx_nullpkt}, {31'd0, e.nul});
        chk("released", {31'd0, txbuf_released_p}, {31'd0, e.rel});
      end
    end else if (txbuf_released_p) begin
      chk("release_without_decision", 32'd1, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic load(input logic [9:0] l);
    mcu_load_p = 1'b1; mcu_load_len = l;
    step();
    mcu_load_p = 1'b0;
  endtask

  // Drive one decision (nw/od/z = sendnew/sendold/send0) with the expected encoder result.
  task automatic decide(input logic nw, od, z, input logic s, input logic [9:0] l,
                        input logic n, r, input logic ld = 1'b0, input logic [9:0] ll = 10'd0,
                        input logic fl = 1'b0);
    exp_t e;
    e.sel = s; e.len = l; e.nul = n; e.rel = r;
    exp_q.push_back(e);
    pk_encode = 1'b1; header_st_p = 1'b1;
    sendnewpy = nw; sendoldpy = od; send0py = z;
    mcu_load_p = ld; mcu_load_len = ll; mcu_flush_p = fl;
    step();
    pk_encode = 1'b0; header_st_p = 1'b0;
    sendnewpy = 1'b0; sendoldpy = 1'b0; send0py = 1'b0;
    mcu_load_p = 1'b0; mcu_flush_p = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wrbuf_sel"}, {31'd0, wrbuf_sel}, 32'd0);
    chk({tag, "_wrbuf_avail"}, {31'd0, wrbuf_avail}, 32'd1);
    chk({tag, "_txbuf_sel"}, {31'd0, txbuf_sel}, 32'd0);
    chk({tag, "_tx_pylen"}, {22'd0, tx_pylen}, 32'd0);
    chk({tag, "_tx_nullpkt"}, {31'd0, tx_nullpkt}, 32'd1);
    chk({tag, "_pulses"}, {29'd0, tx_decision_p, txbuf_released_p, flush_done_p}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, load_overrun}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; connsnew_p = 1'b0; mcu_load_p = 1'b0; mcu_flush_p = 1'b0; mcu_load_len = 10'd0;
    pk_encode = 1'b0; header_st_p = 1'b0; sendnewpy = 1'b0; sendoldpy = 1'b0; send0py = 1'b0;
    repeat (3) step();
    chk_reset_state("reset");
    rst = 1'b0;
    step();

    // Single payload cycle
    load(10'd27);
    chk("load0_wrsel", {31'd0, wrbuf_sel}, 32'd1);
    chk("load0_avail", {31'd0, wrbuf_avail}, 32'd1);
    decide(0, 1, 0, 1'b0, 10'd27, 1'b0, 1'b0);
    chk("dec_pulse_one_cycle", {31'd0, tx_decision_p}, 32'd1);
    step();
    chk("dec_pulse_drop", {31'd0, tx_decision_p}, 32'd0);
    chk("hold_pylen", {22'd0, tx_pylen}, 32'd27);
    decide(1, 0, 0, 1'b0, 10'd0, 1'b1, 1'b1);
    chk("free_avail", {31'd0, wrbuf_avail}, 32'd1);
    chk("free_wrsel", {31'd0, wrbuf_sel}, 32'd0);
    step();
    chk("rel_pulse_drop", {31'd0, txbuf_released_p}, 32'd0);

    // Queue ordering
    load(10'd10);
    load(10'd20);
    chk("both_loaded_avail", {31'd0, wrbuf_avail}, 32'd0);
    decide(1, 0, 0, 1'b0, 10'd10, 1'b0, 1'b0);
    decide(1, 0, 0, 1'b1, 10'd20, 1'b0, 1'b1);
    chk("order_wrsel", {31'd0, wrbuf_sel}, 32'd0);
    chk("order_avail", {31'd0, wrbuf_avail}, 32'd1);

    // Retransmit and zero-length with buffer 1 in flight (len 183)
    decide(1, 0, 0, 1'b1, 10'd0, 1'b1, 1'b1);
    load(10'd1);
    load(10'd183);
    decide(1, 0, 0, 1'b0, 10'd1, 1'b0, 1'b0);
    decide(1, 0, 0, 1'b1, 10'd183, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) decide(0, 1, 0, 1'b1, 10'd183, 1'b0, 1'b0);
    decide(0, 0, 1, 1'b1, 10'd0, 1'b0, 1'b0);
    decide(0, 1, 1, 1'b1, 10'd0, 1'b0, 1'b0);
    decide(0, 1, 0, 1'b1, 10'd183, 1'b0, 1'b0);

    // Non-ACL decision point: nothing changes, no pulse
    pk_encode = 1'b1; header_st_p = 1'b1;
    step();
    pk_encode = 1'b0; header_st_p = 1'b0;
    chk("nonacl_no_pulse", {31'd0, tx_decision_p}, 32'd0);
    chk("nonacl_hold", {22'd0, tx_pylen}, 32'd183);

    // Overrun, then connsnew clears everything
    load(10'd50);
    chk("full_avail", {31'd0, wrbuf_avail}, 32'd0);
    load(10'd99);
    chk("overrun_set", {31'd0, load_overrun}, 32'd1);
    step();
    chk("overrun_sticky", {31'd0, load_overrun}, 32'd1);
    decide(0, 1, 0, 1'b1, 10'd183, 1'b0, 1'b0);
    decide(1, 0, 0, 1'b0, 10'd50, 1'b0, 1'b1);
    connsnew_p = 1'b1;
    step();
    connsnew_p = 1'b0;
    chk_reset_state("connsnew");
    decide(0, 1, 0, 1'b0, 10'd0, 1'b1, 1'b0);

    // Flush versus decision
    load(10'd33);
    decide(1, 0, 0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1);
    chk("flush_done", {31'd0, flush_done_p}, 32'd1);
    chk("flush_avail", {31'd0, wrbuf_avail}, 32'd1);
    chk("flush_wrsel", {31'd0, wrbuf_sel}, 32'd0);
    step();
    chk("flush_done_drop", {31'd0, flush_done_p}, 32'd0);
    decide(0, 1, 0, 1'b0, 10'd0, 1'b1, 1'b0);

    // Load in the decision cycle
    load(10'd7);
    load(10'd8);
    decide(1, 0, 0, 1'b0, 10'd7, 1'b0, 1'b0);
    decide(1, 0, 0, 1'b1, 10'd8, 1'b0, 1'b1);
    decide(1, 0, 0, 1'b1, 10'd0, 1'b1, 1'b1, 1'b1, 10'd5);
    chk("ldec_wrsel", {31'd0, wrbuf_sel}, 32'd1);
    chk("ldec_avail", {31'd0, wrbuf_avail}, 32'd1);
    decide(0, 1, 0, 1'b0, 10'd5, 1'b0, 1'b0);

    // Reset mid-operation
    load(10'd44);
    pk_encode = 1'b1; header_st_p = 1'b1; sendnewpy = 1'b1;
    @(posedge clk_6M);
    #2;
    rst = 1'b1;
    pk_encode = 1'b0; header_st_p = 1'b0; sendnewpy = 1'b0;
    #1;
    chk_reset_state("midrst");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    chk("midrst_no_pulse", {31'd0, tx_decision_p}, 32'd0);

    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
